// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared core encodings for the writeback stage
package writeback_unit_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_NONE = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_unit_load_align.sv
// rtl/writeback_unit_load_align.sv - load byte/halfword selection and extension
module wb_load_align
    import writeback_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] load_data,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend according to load type
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = load_data[7:0];
            2'd1:    byte_sel = load_data[15:8];
            2'd2:    byte_sel = load_data[23:16];
            default: byte_sel = load_data[31:24];
        endcase
        half_sel = addr_lo[1] ? load_data[31:16] : load_data[15:0];
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = load_data;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - buffered register-file writeback with pending-write lookup
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_load_data,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        wb_stall,
    output logic [4:0]  rf_addr_rd,
    output logic [31:0] rf_data_rd,
    output logic        rf_write_enable,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    output logic        q_hit1,
    output logic        q_hit2,
    output logic [31:0] q_data1,
    output logic [31:0] q_data2,
    output logic [31:0] retire_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       entry_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     load_word;
    logic [31:0]     enq_data;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;

    wb_load_align u_align (
        .funct3    (in_funct3),
        .addr_lo   (in_addr_lo),
        .load_data (in_load_data),
        .result    (load_word)
    );

    assign empty           = (count == '0);
    assign full            = (count == CW'(DEPTH));
    assign in_ready        = !full;
    // Results without a real destination are consumed but never stored
    assign push            = in_valid && in_ready && (in_rd != 5'd0) && (in_wb_sel != WB_NONE);
    assign rf_write_enable = !empty && !wb_stall;
    assign pop             = rf_write_enable;
    assign rf_addr_rd      = empty ? 5'd0  : entry_mem[rd_ptr].rd;
    assign rf_data_rd      = empty ? 32'd0 : entry_mem[rd_ptr].data;

    // Resolve the final register value at enqueue time
    always_comb begin
        case (in_wb_sel)
            WB_LOAD: enq_data = load_word;
            WB_PC4:  enq_data = in_pc + 32'd4;
            default: enq_data = in_alu;
        endcase
    end

    // Entry storage needs no reset; occupancy decides validity
    always_ff @(posedge clock) begin
        if (push) begin
            entry_mem[wr_ptr] <= '{rd: in_rd, data: enq_data};
        end
    end

    // Pointers, occupancy and retire counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            retire_count <= 32'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr       <= rd_ptr + PW'(1);
                retire_count <= retire_count + 32'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        logic [PW-1:0] idx;
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = 32'd0;
        q_data2 = 32'd0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (q_rs1 != 5'd0 && entry_mem[idx].rd == q_rs1) begin
                    q_hit1  = 1'b1;
                    q_data1 = entry_mem[idx].data;
                end
                if (q_rs2 != 5'd0 && entry_mem[idx].rd == q_rs2) begin
                    q_hit2  = 1'b1;
                    q_data2 = entry_mem[idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit
module tb_writeback_unit;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu;
    logic [31:0] in_pc;
    logic [31:0] in_load_data;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        wb_stall;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;
    logic        rf_write_enable;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        q_hit1;
    logic        q_hit2;
    logic [31:0] q_data1;
    logic [31:0] q_data2;
    logic [31:0] retire_count;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_rd           (in_rd),
        .in_wb_sel       (in_wb_sel),
        .in_alu          (in_alu),
        .in_pc           (in_pc),
        .in_load_data    (in_load_data),
        .in_funct3       (in_funct3),
        .in_addr_lo      (in_addr_lo),
        .wb_stall        (wb_stall),
        .rf_addr_rd      (rf_addr_rd),
        .rf_data_rd      (rf_data_rd),
        .rf_write_enable (rf_write_enable),
        .q_rs1           (q_rs1),
        .q_rs2           (q_rs2),
        .q_hit1          (q_hit1),
        .q_hit2          (q_hit2),
        .q_data1         (q_data1),
        .q_data2         (q_data2),
        .retire_count    (retire_count)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } m_entry_t;

    m_entry_t    mq[$];
    logic [31:0] m_retire;

    function automatic logic [31:0] m_value(input logic [1:0] sel, input logic [2:0] f3,
                                            input logic [1:0] alo, input logic [31:0] ld,
                                            input logic [31:0] alu, input logic [31:0] pc);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = ld >> (8 * alo);
        b  = sh[7:0];
        sh = ld >> (16 * alo[1]);
        h  = sh[15:0];
        if (sel == 2'd0) return alu;
        if (sel == 2'd2) return pc + 32'd4;
        if (f3 == 3'd0) return 32'($signed(b));
        if (f3 == 3'd4) return {24'd0, b};
        if (f3 == 3'd1) return 32'($signed(h));
        if (f3 == 3'd5) return {16'd0, h};
        return ld;
    endfunction

    // Reference model of the buffer contents
    always @(posedge clock or negedge reset_n) begin
        bit acc_now;
        bit pop_now;
        if (!reset_n) begin
            mq.delete();
            m_retire <= 32'd0;
        end else begin
            acc_now = in_valid && (mq.size() < DEPTH);
            pop_now = (mq.size() > 0) && !wb_stall;
            if (pop_now) begin
                void'(mq.pop_front());
                m_retire <= m_retire + 32'd1;
            end
            if (acc_now && in_rd != 5'd0 && in_wb_sel != 2'd3)
                mq.push_back('{rd: in_rd, data: m_value(in_wb_sel, in_funct3, in_addr_lo,
                                                        in_load_data, in_alu, in_pc)});
        end
    end

    // Per-cycle comparison against the model, away from the clock edge
    always @(negedge clock) begin
        logic        h1, h2;
        logic [31:0] d1, d2;
        h1 = 0; h2 = 0; d1 = 0; d2 = 0;
        foreach (mq[k]) begin
            if (q_rs1 != 0 && mq[k].rd == q_rs1) begin h1 = 1; d1 = mq[k].data; end
            if (q_rs2 != 0 && mq[k].rd == q_rs2) begin h2 = 1; d2 = mq[k].data; end
        end
        check("in_ready",  32'(in_ready),        32'(mq.size() < DEPTH));
        check("wen",       32'(rf_write_enable), 32'(mq.size() > 0 && !wb_stall));
        check("rf_addr",   32'(rf_addr_rd),      mq.size() > 0 ? 32'(mq[0].rd) : 32'd0);
        check("rf_data",   rf_data_rd,           mq.size() > 0 ? mq[0].data : 32'd0);
        check("retire",    retire_count,         m_retire);
        check("q_hit1",    32'(q_hit1),          32'(h1));
        check("q_data1",   q_data1,              d1);
        check("q_hit2",    32'(q_hit2),          32'(h2));
        check("q_data2",   q_data2,              d2);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic enq(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [1:0] alo, input logic [31:0] ld,
                       input logic [31:0] alu, input logic [31:0] pc);
        in_valid = 1; in_rd = rd; in_wb_sel = sel; in_funct3 = f3;
        in_addr_lo = alo; in_load_data = ld; in_alu = alu; in_pc = pc;
        cyc();
        in_valid = 0;
    endtask

    initial begin
        reset_n = 0; in_valid = 0; in_rd = 0; in_wb_sel = 0; in_alu = 0; in_pc = 0;
        in_load_data = 0; in_funct3 = 0; in_addr_lo = 0; wb_stall = 0; q_rs1 = 0; q_rs2 = 0;
        cyc(); cyc();
        check("rst_ready",  32'(in_ready), 32'd1);
        check("rst_wen",    32'(rf_write_enable), 32'd0);
        check("rst_retire", retire_count, 32'd0);
        reset_n = 1;
        cyc();

        // LW rd=5, no same-cycle pass-through
        in_valid = 1; in_rd = 5; in_wb_sel = 2'd1; in_funct3 = 3'd2; in_load_data = 32'hDEADBEEF;
        #1;
        check("lw_no_bypass", 32'(rf_write_enable), 32'd0);
        cyc();
        in_valid = 0;
        check("lw_wen",  32'(rf_write_enable), 32'd1);
        check("lw_addr", 32'(rf_addr_rd), 32'd5);
        check("lw_data", rf_data_rd, 32'hDEADBEEF);
        cyc();
        check("lw_retire", retire_count, 32'd1);

        // Load alignment cases
        enq(5'd3, 2'd1, 3'd0, 2'd1, 32'h0000_8000, 0, 0);
        check("lb",  rf_data_rd, 32'hFFFFFF80);
        cyc();
        enq(5'd3, 2'd1, 3'd4, 2'd1, 32'h0000_8000, 0, 0);
        check("lbu", rf_data_rd, 32'h00000080);
        cyc();
        enq(5'd4, 2'd1, 3'd1, 2'd2, 32'h8001_0000, 0, 0);
        check("lh",  rf_data_rd, 32'hFFFF8001);
        cyc();

        // Back-pressure with stalled write port
        wb_stall = 1; q_rs1 = 2; q_rs2 = 1;
        enq(5'd1, 2'd0, 0, 0, 0, 32'h11, 0);
        enq(5'd2, 2'd0, 0, 0, 0, 32'h22, 0);
        in_valid = 1; in_rd = 3; in_wb_sel = 2'd0; in_alu = 32'h33;
        #1;
        check("full_ready", 32'(in_ready), 32'd0);
        cyc();
        check("held_ready", 32'(in_ready), 32'd0);
        wb_stall = 0;
        #1;
        check("drain1_addr", 32'(rf_addr_rd), 32'd1);
        cyc();
        check("drain2_addr", 32'(rf_addr_rd), 32'd2);
        cyc();
        in_valid = 0;
        check("drain3_addr", 32'(rf_addr_rd), 32'd3);
        check("drain3_data", rf_data_rd, 32'h33);
        cyc();
        check("drain_retire", retire_count, 32'd7);

        // Youngest-match lookup
        wb_stall = 1; q_rs1 = 0; q_rs2 = 0;
        enq(5'd7, 2'd0, 0, 0, 0, 32'd1, 0);
        enq(5'd7, 2'd0, 0, 0, 0, 32'd2, 0);
        q_rs1 = 7; q_rs2 = 0;
        #1;
        check("hit1",  32'(q_hit1), 32'd1);
        check("data1", q_data1, 32'd2);
        check("hit2",  32'(q_hit2), 32'd0);

        // Mid-operation reset discards pending entries
        wb_stall = 0; reset_n = 0;
        #1;
        check("mrst_wen",   32'(rf_write_enable), 32'd0);
        check("mrst_addr",  32'(rf_addr_rd), 32'd0);
        check("mrst_data",  rf_data_rd, 32'd0);
        check("mrst_hit1",  32'(q_hit1), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_ret",   retire_count, 32'd0);
        cyc();
        reset_n = 1;
        cyc(); cyc();
        check("post_rst_wen", 32'(rf_write_enable), 32'd0);
        check("post_rst_ret", retire_count, 32'd0);

        // Discarded results and PC+4 wrap
        q_rs1 = 0;
        enq(5'd0, 2'd0, 0, 0, 0, 32'h55, 0);
        check("rd0_wen", 32'(rf_write_enable), 32'd0);
        enq(5'd3, 2'd3, 0, 0, 0, 32'h66, 0);
        check("none_wen", 32'(rf_write_enable), 32'd0);
        check("none_ret", retire_count, 32'd0);
        enq(5'd1, 2'd2, 0, 0, 0, 0, 32'hFFFFFFFC);
        check("jal_wen",  32'(rf_write_enable), 32'd1);
        check("jal_data", rf_data_rd, 32'h00000000);
        cyc();
        check("jal_ret", retire_count, 32'd1);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
